// File: rtl/moore_seq_pkg.sv
// moore_seq_pkg: state encodings and default sizing shared by the sequence generator
// and the top level that maps the state onto its debug outputs.
`default_nettype none

package moore_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_LEN_W = 4;
    localparam int DEF_CNT_W = 4;

endpackage

`default_nettype wire

// File: rtl/moore_seq_shifter.sv
// moore_seq_shifter: loadable left-aligning shift register with a bits-remaining counter.
`default_nettype none

module moore_seq_shifter #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] pattern_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             msb_o,
    output logic             last_bit_o
);

    logic [WIDTH-1:0] sreg_q;
    logic [LEN_W-1:0] bcnt_q;

    // Zeros shift in from the right, so the register is empty once all len bits are out;
    // that keeps msb_o low outside a burst without extra gating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_q <= '0;
            bcnt_q <= '0;
        end else if (clear_i) begin
            sreg_q <= '0;
            bcnt_q <= '0;
        end else if (load_i) begin
            sreg_q <= pattern_i << (LEN_W'(WIDTH) - len_i);
            bcnt_q <= len_i;
        end else if (shift_i) begin
            sreg_q <= {sreg_q[WIDTH-2:0], 1'b0};
            bcnt_q <= bcnt_q - LEN_W'(1);
        end
    end

    assign msb_o      = sreg_q[WIDTH-1];
    assign last_bit_o = (bcnt_q == LEN_W'(1));

endmodule

`default_nettype wire

// File: rtl/moore_seq_gen.sv
// moore_seq_gen: serial pattern transmitter, MSB-first bursts with optional idle gaps,
// busy/done handshake and abort.
`default_nettype none

module moore_seq_gen
    import moore_seq_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int LEN_W      = DEF_LEN_W,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int GAP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [WIDTH-1:0] pattern_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic [CNT_W-1:0] repeat_n_i,
    output logic             x1_o,
    output logic             bit_valid_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [1:0]       state_o
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic [CNT_W-1:0] rep_q, rep_d;
    logic [GW-1:0]    gcnt_q, gcnt_d;
    logic             bit_valid_q, busy_q, done_q;

    logic             sh_load, sh_shift, sh_last, sh_msb;
    logic [LEN_W-1:0] len_clamp;
    logic [WIDTH-1:0] ld_pat;
    logic [LEN_W-1:0] ld_len;
    logic             accept;

    assign len_clamp = (len_i > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : len_i;
    assign accept    = (state_q == ST_IDLE) && start_i && !abort_i;

    // The first burst loads straight from the ports; repeats reload the captured copy.
    assign ld_pat = (state_q == ST_IDLE) ? pattern_i : pat_q;
    assign ld_len = (state_q == ST_IDLE) ? len_clamp : len_q;

    always_comb begin
        state_d  = state_q;
        rep_d    = rep_q;
        gcnt_d   = gcnt_q;
        sh_load  = 1'b0;
        sh_shift = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    rep_d = repeat_n_i;
                    if (len_clamp == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SHIFT;
                        sh_load = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                sh_shift = 1'b1;
                if (sh_last) begin
                    if (rep_q != '0) begin
                        rep_d = rep_q - CNT_W'(1);
                        if (GAP_CYCLES > 0) begin
                            state_d = ST_GAP;
                            gcnt_d  = GW'(GAP_CYCLES - 1);
                        end else begin
                            sh_load = 1'b1;
                        end
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_GAP: begin
                if (gcnt_q == '0) begin
                    state_d = ST_SHIFT;
                    sh_load = 1'b1;
                end else begin
                    gcnt_d = gcnt_q - GW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort_i) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pat_q       <= '0;
            len_q       <= '0;
            rep_q       <= '0;
            gcnt_q      <= '0;
            bit_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rep_q       <= rep_d;
            gcnt_q      <= gcnt_d;
            bit_valid_q <= (state_d == ST_SHIFT);
            busy_q      <= (state_d == ST_SHIFT) || (state_d == ST_GAP);
            done_q      <= (state_d == ST_DONE);
            if (accept) begin
                pat_q <= pattern_i;
                len_q <= len_clamp;
            end
        end
    end

    moore_seq_shifter #(
        .WIDTH (WIDTH),
        .LEN_W (LEN_W)
    ) u_shifter (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (abort_i),
        .load_i     (sh_load),
        .shift_i    (sh_shift),
        .pattern_i  (ld_pat),
        .len_i      (ld_len),
        .msb_o      (sh_msb),
        .last_bit_o (sh_last)
    );

    assign x1_o        = sh_msb;
    assign bit_valid_o = bit_valid_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign state_o     = state_q;

endmodule

`default_nettype wire

// File: tb/tb_moore_seq_gen.sv
// tb_moore_seq_gen: directed-vector bench for moore_seq_gen with hand-computed expectations.
`default_nettype none

module tb_moore_seq_gen;

    localparam int WIDTH = 8;
    localparam int LEN_W = 4;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start, abort;
    logic [WIDTH-1:0] pattern;
    logic [LEN_W-1:0] len;
    logic [CNT_W-1:0] repeat_n;
    logic             x1, bit_valid, busy, done;
    logic [1:0]       state;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    moore_seq_gen #(
        .WIDTH      (WIDTH),
        .LEN_W      (LEN_W),
        .CNT_W      (CNT_W),
        .GAP_CYCLES (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start),
        .abort_i     (abort),
        .pattern_i   (pattern),
        .len_i       (len),
        .repeat_n_i  (repeat_n),
        .x1_o        (x1),
        .bit_valid_o (bit_valid),
        .busy_o      (busy),
        .done_o      (done),
        .state_o     (state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Packed order: x1, bit_valid, busy, done, state[1:0]
    task automatic chk_out(input string tag, input logic ex, input logic ev, input logic eb,
                           input logic ed, input logic [1:0] es);
        chk(tag, {26'd0, x1, bit_valid, busy, done, state}, {26'd0, ex, ev, eb, ed, es});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [WIDTH-1:0] p, input logic [LEN_W-1:0] l,
                          input logic [CNT_W-1:0] r);
        pattern  = p;
        len      = l;
        repeat_n = r;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        pattern  = ~p;
        len      = 4'd3;
        repeat_n = 4'd7;
    endtask

    initial begin
        logic [3:0] b0b;
        logic [7:0] a5;
        int         cyc, nv;

        b0b      = 4'b1011;
        a5       = 8'hA5;
        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        pattern  = '0;
        len      = '0;
        repeat_n = '0;
        #12;
        chk_out("reset_state", 0, 0, 0, 0, 2'd0);
        rst_n = 1'b1;
        tick();
        chk_out("idle_after_reset", 0, 0, 0, 0, 2'd0);

        // Single burst, 0x0B len 4
        launch(8'h0B, 4'd4, 4'd0);
        for (int k = 0; k < 4; k++) begin
            chk_out($sformatf("t1_bit%0d", k), b0b[3-k], 1, 1, 0, 2'd1);
            tick();
        end
        chk_out("t1_done", 0, 0, 0, 1, 2'd3);
        tick();
        chk_out("t1_idle", 0, 0, 0, 0, 2'd0);

        // Three bursts with one-cycle gaps; start pulsed while busy is ignored
        launch(8'h0B, 4'd4, 4'd2);
        for (int c = 1; c <= 14; c++) begin
            if ((c - 1) % 5 < 4)
                chk_out($sformatf("t2_c%0d", c), b0b[3-((c-1)%5)], 1, 1, 0, 2'd1);
            else
                chk_out($sformatf("t2_gap_c%0d", c), 0, 0, 1, 0, 2'd2);
            start   = (c == 3);
            pattern = 8'hFF;
            len     = 4'd8;
            tick();
        end
        start = 1'b0;
        chk_out("t2_done_c15", 0, 0, 0, 1, 2'd3);
        tick();
        chk_out("t2_idle", 0, 0, 0, 0, 2'd0);

        // Abort on 4th bit of 0xA5
        launch(a5, 4'd8, 4'd0);
        for (int k = 0; k < 4; k++) begin
            chk_out($sformatf("t3_bit%0d", k), a5[7-k], 1, 1, 0, 2'd1);
            if (k < 3) tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_out("t3_aborted", 0, 0, 0, 0, 2'd0);
        for (int k = 0; k < 5; k++) begin
            chk(("t3_no_done"), {31'd0, done}, 32'd0);
            tick();
        end
        launch(8'h02, 4'd2, 4'd0);
        chk_out("t3_restart_b0", 1, 1, 1, 0, 2'd1);
        tick();
        chk_out("t3_restart_b1", 0, 1, 1, 0, 2'd1);
        tick();
        chk_out("t3_restart_done", 0, 0, 0, 1, 2'd3);
        tick();

        // Empty request
        launch(8'hFF, 4'd0, 4'd3);
        chk_out("t4_len0_done", 0, 0, 0, 1, 2'd3);
        tick();
        chk_out("t4_len0_idle", 0, 0, 0, 0, 2'd0);

        // Abort wins over simultaneous start
        pattern = 8'hFF;
        len     = 4'd4;
        start   = 1'b1;
        abort   = 1'b1;
        tick();
        start   = 1'b0;
        abort   = 1'b0;
        chk_out("abort_over_start", 0, 0, 0, 0, 2'd0);

        // len above WIDTH clamps to WIDTH: 0x81 -> 1000_0001
        launch(8'h81, 4'd15, 4'd0);
        for (int k = 0; k < 8; k++) begin
            chk_out($sformatf("clamp_bit%0d", k), (k == 0 || k == 7), 1, 1, 0, 2'd1);
            tick();
        end
        chk_out("clamp_done", 0, 0, 0, 1, 2'd3);
        tick();

        // Max repeat count: 16 one-bit bursts, 15 gaps, done at T+32
        launch(8'h01, 4'd1, 4'd15);
        cyc = 1;
        nv  = 0;
        while (!done && cyc < 60) begin
            if (bit_valid) nv++;
            tick();
            cyc++;
        end
        chk("rmax_latency", cyc, 32);
        chk("rmax_bursts", nv, 16);
        tick();

        // Async reset mid-burst, asserted away from the clock edge
        launch(8'hFF, 4'd8, 4'd1);
        tick();
        chk_out("t5_pre_reset", 1, 1, 1, 0, 2'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("t5_async_reset", 0, 0, 0, 0, 2'd0);
        #3;
        rst_n = 1'b1;
        tick();
        chk_out("t5_after_release", 0, 0, 0, 0, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
